axi_wr_arbiter_2to1: RTL
========================

// Module: axi_wr_arbiter_2to1
// PURPOSE
//  Shares one AXI write-slave port (AW/W/B) between two write masters M0/M1.
//  Round-robin arbitration per complete transaction: grant held from AW through the B handshake.
//  One outstanding transaction at a time; IDs pass through unchanged.
//  Beats are counted against AWLEN; the slave sees LAST generated from the count.
//  Sits between the bus-side masters and a single slave (memory, regfile or default slave).
// PARAMETERS
//  ID_WIDTH    4   AXI ID width
//  ADDR_WIDTH  32  address width
//  DATA_WIDTH  32  data width; strobe width is DATA_WIDTH/8
// PORTS  (x in {0,1}: one port per master, Mx_*; S_* faces the slave)
//  CLK                    in   1        single clock for all channels
//  RST                    in   1        synchronous, active-high reset
//  Mx_WR_ADDR_ID          in   ID       master AW ID
//  Mx_WR_ADDR             in   ADDR     master AW address
//  Mx_WR_ADDR_LEN         in   8        master AW length (beats-1)
//  Mx_WR_ADDR_BURST       in   2        master AW burst type
//  Mx_WR_ADDR_VALID       in   1        master AW valid
//  Mx_WR_ADDR_READY       out  1        master AW ready
//  Mx_WR_DATA/_STRB       in   DATA/DW8 master W data and strobe
//  Mx_WR_DATA_LAST        in   1        master W last
//  Mx_WR_DATA_VALID       in   1        master W valid
//  Mx_WR_DATA_READY       out  1        master W ready
//  Mx_WR_BACK_ID/_RESP    out  ID/2     B ID and response to master
//  Mx_WR_BACK_VALID       out  1        B valid to master
//  Mx_WR_BACK_READY       in   1        B ready from master
//  S_WR_ADDR_ID/_ADDR/_LEN/_BURST  out  ID/ADDR/8/2  routed AW fields
//  S_WR_ADDR_VALID        out  1        AW valid to slave
//  S_WR_ADDR_READY        in   1        AW ready from slave
//  S_WR_DATA/_STRB        out  DATA/DW8 routed W data and strobe
//  S_WR_DATA_LAST         out  1        generated last (count == LEN)
//  S_WR_DATA_VALID        out  1        W valid to slave
//  S_WR_DATA_READY        in   1        W ready from slave
//  S_WR_BACK_ID/_RESP/_VALID  in  ID/2/1  slave B response
//  S_WR_BACK_READY        out  1        B ready to slave
//  GRANT_OWNER            out  1        current/last granted master
//  ERR_LAST               out  1        1-cycle pulse on master LAST/count mismatch
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (M0 wins first tie), beat_cnt=0, len_q=0, err_q=0.
//   Next cycle all VALID/READY outputs, ERR_LAST and GRANT_OWNER are 0; routed S_* fields are 0.
//  FSM IDLE->ADDR->DATA->RESP->IDLE:
//  IDLE: a master requests if Mx_WR_ADDR_VALID=1. Only one requests -> grant it.
//   Both request -> grant the master other than last_grant. Grant is registered, so ADDR
//   follows 1 cycle later. No ready is asserted in IDLE.
//  ADDR: S_WR_ADDR_* = granted master's AW; its READY = S_WR_ADDR_READY; other master READY=0.
//   On handshake: latch len_q=LEN, clear beat_cnt, go to DATA.
//  DATA: W channel routed from the granted master; ready passes through; S_WR_DATA_LAST=(beat_cnt==len_q).
//   Each handshake: beat_cnt+1 (8-bit). On the handshake with beat_cnt==len_q go to RESP.
//   Master LAST != (beat_cnt==len_q) on any handshake: ERR_LAST pulses next cycle, err_q=1.
//   Beats continue; the transfer ends on the count only, so a LEN=255 burst ends cleanly with no wrap.
//  RESP: S_WR_BACK_ID/VALID routed to the granted master; S_WR_BACK_READY = its BACK_READY.
//   RESP forwarded unchanged if err_q=0, forced to 2'b10 (SLVERR) if err_q=1.
//   On handshake: last_grant=granted, err_q=0, go to IDLE.
//  Non-granted master: READY=0, BACK_VALID=0, BACK_ID/RESP=0 in all states.
//  Throughput: AW handshake to first W beat possible in the same cycle as entering DATA.
//   Minimum cycles per single-beat transaction: 4.
//  RST asserted in any state aborts the transaction; outputs return to reset values the next cycle.
// TESTING
//  M0 only, LEN=3, slave always ready -> 4 beats routed, S LAST on 4th beat, M0 gets B OKAY; M1 READY=0 throughout.
//  M0/M1 AW valid in the same cycle after reset -> M0 served first, then M1.
//   Repeat the pair -> M0 then M1 again; GRANT_OWNER follows.
//  M1 holds AW valid during an M0 burst with slave W ready toggling 1/0 -> M1 not granted until M0's B handshake; no beat lost.
//  M0 LEN=1 with LAST on beat 0 -> ERR_LAST pulse; 2 beats still sent; M0 B RESP=2'b10.
//  LEN=255 -> 256 beats, LAST only on beat 255, return to IDLE.
//  RST raised mid-DATA (beat 2 of 8) -> all VALID/READY 0 next cycle; new M1 request served cleanly afterwards.

Source files
------------

// File: rtl/axi_wr_arbiter_2to1_if.sv
// AXI write channels (AW/W/B) as one bundle. The master modport drives
// requests; the slave modport accepts them and returns the B response.
interface axi_wr_arbiter_2to1_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     wr_addr_id;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [7:0]              wr_addr_len;
  logic [1:0]              wr_addr_burst;
  logic                    wr_addr_valid;
  logic                    wr_addr_ready;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_data_strb;
  logic                    wr_data_last;
  logic                    wr_data_valid;
  logic                    wr_data_ready;
  logic [ID_WIDTH-1:0]     wr_back_id;
  logic [1:0]              wr_back_resp;
  logic                    wr_back_valid;
  logic                    wr_back_ready;

  modport master (
    output wr_addr_id, wr_addr, wr_addr_len, wr_addr_burst, wr_addr_valid,
    output wr_data, wr_data_strb, wr_data_last, wr_data_valid,
    output wr_back_ready,
    input  wr_addr_ready, wr_data_ready,
    input  wr_back_id, wr_back_resp, wr_back_valid
  );

  modport slave (
    input  wr_addr_id, wr_addr, wr_addr_len, wr_addr_burst, wr_addr_valid,
    input  wr_data, wr_data_strb, wr_data_last, wr_data_valid,
    input  wr_back_ready,
    output wr_addr_ready, wr_data_ready,
    output wr_back_id, wr_back_resp, wr_back_valid
  );
endinterface

// File: rtl/axi_wr_arbiter_2to1.sv
// 2:1 AXI write arbiter. One transaction is outstanding at a time, masters are
// granted round-robin per whole AW/W/B exchange, and the slave LAST comes from the beat count.
module axi_wr_arbiter_2to1 #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_wr_arbiter_2to1_if.slave  m0,
  axi_wr_arbiter_2to1_if.slave  m1,
  axi_wr_arbiter_2to1_if.master s,
  output logic                  grant_owner,
  output logic                  err_last
);
  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q;
  logic [7:0] beat_cnt_q, len_q;
  logic       err_q, err_pulse_q;

  // Channel fields of whichever master currently holds the grant.
  logic [ID_WIDTH-1:0]   g_aw_id;
  logic [ADDR_WIDTH-1:0] g_aw_addr;
  logic [7:0]            g_aw_len;
  logic [1:0]            g_aw_burst;
  logic                  g_aw_valid;
  logic [DATA_WIDTH-1:0] g_w_data;
  logic [STRB_WIDTH-1:0] g_w_strb;
  logic                  g_w_last;
  logic                  g_w_valid;
  logic                  g_b_ready;
  logic [1:0]            b_resp;
  logic                  cnt_last, aw_hs, w_hs, b_hs;

  assign g_aw_id    = grant_q ? m1.wr_addr_id    : m0.wr_addr_id;
  assign g_aw_addr  = grant_q ? m1.wr_addr       : m0.wr_addr;
  assign g_aw_len   = grant_q ? m1.wr_addr_len   : m0.wr_addr_len;
  assign g_aw_burst = grant_q ? m1.wr_addr_burst : m0.wr_addr_burst;
  assign g_aw_valid = grant_q ? m1.wr_addr_valid : m0.wr_addr_valid;
  assign g_w_data   = grant_q ? m1.wr_data       : m0.wr_data;
  assign g_w_strb   = grant_q ? m1.wr_data_strb  : m0.wr_data_strb;
  assign g_w_last   = grant_q ? m1.wr_data_last  : m0.wr_data_last;
  assign g_w_valid  = grant_q ? m1.wr_data_valid : m0.wr_data_valid;
  assign g_b_ready  = grant_q ? m1.wr_back_ready : m0.wr_back_ready;

  assign cnt_last = (beat_cnt_q == len_q);
  assign aw_hs    = (state_q == ADDR) && g_aw_valid && s.wr_addr_ready;
  assign w_hs     = (state_q == DATA) && g_w_valid && s.wr_data_ready;
  assign b_hs     = (state_q == RESP) && s.wr_back_valid && g_b_ready;
  assign b_resp   = err_q ? RESP_SLVERR : s.wr_back_resp;

  assign grant_owner = grant_q;
  assign err_last    = err_pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d          = state_q;
    grant_d          = grant_q;
    s.wr_addr_id     = '0;
    s.wr_addr        = '0;
    s.wr_addr_len    = '0;
    s.wr_addr_burst  = '0;
    s.wr_addr_valid  = 1'b0;
    s.wr_data        = '0;
    s.wr_data_strb   = '0;
    s.wr_data_last   = 1'b0;
    s.wr_data_valid  = 1'b0;
    s.wr_back_ready  = 1'b0;
    m0.wr_addr_ready = 1'b0;
    m0.wr_data_ready = 1'b0;
    m0.wr_back_id    = '0;
    m0.wr_back_resp  = '0;
    m0.wr_back_valid = 1'b0;
    m1.wr_addr_ready = 1'b0;
    m1.wr_data_ready = 1'b0;
    m1.wr_back_id    = '0;
    m1.wr_back_resp  = '0;
    m1.wr_back_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0.wr_addr_valid || m1.wr_addr_valid) begin
          state_d = ADDR;
          // On a tie the master that did not win last time goes first.
          if (m0.wr_addr_valid && m1.wr_addr_valid) grant_d = ~last_grant_q;
          else                                      grant_d = m1.wr_addr_valid;
        end
      end
      ADDR: begin
        s.wr_addr_id     = g_aw_id;
        s.wr_addr        = g_aw_addr;
        s.wr_addr_len    = g_aw_len;
        s.wr_addr_burst  = g_aw_burst;
        s.wr_addr_valid  = g_aw_valid;
        m0.wr_addr_ready = !grant_q && s.wr_addr_ready;
        m1.wr_addr_ready =  grant_q && s.wr_addr_ready;
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        s.wr_data        = g_w_data;
        s.wr_data_strb   = g_w_strb;
        s.wr_data_last   = cnt_last;
        s.wr_data_valid  = g_w_valid;
        m0.wr_data_ready = !grant_q && s.wr_data_ready;
        m1.wr_data_ready =  grant_q && s.wr_data_ready;
        if (w_hs && cnt_last) state_d = RESP;
      end
      RESP: begin
        s.wr_back_ready = g_b_ready;
        if (grant_q) begin
          m1.wr_back_id    = s.wr_back_id;
          m1.wr_back_resp  = b_resp;
          m1.wr_back_valid = s.wr_back_valid;
        end else begin
          m0.wr_back_id    = s.wr_back_id;
          m0.wr_back_resp  = b_resp;
          m0.wr_back_valid = s.wr_back_valid;
        end
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counting, LAST checking and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (aw_hs) begin
        len_q      <= g_aw_len;
        beat_cnt_q <= '0;
      end
      if (w_hs) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        // A wrong master LAST is flagged but the burst still ends on the count.
        if (g_w_last != cnt_last) begin
          err_pulse_q <= 1'b1;
          err_q       <= 1'b1;
        end
      end
      if (b_hs) begin
        last_grant_q <= grant_q;
        err_q        <= 1'b0;
      end
    end
  end
endmodule
